// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// payload-buffer commands, the fault filler instruction and the default boot address.
package ifu_pkg;

  localparam int unsigned IFU_DATA_LEN = 32;
  localparam logic [31:0] IFU_RST_PC   = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } ifu_state_e;

  typedef enum logic [1:0] {
    BUF_HOLD  = 2'd0,
    BUF_LOAD  = 2'd1,
    BUF_CLEAR = 2'd2
  } buf_op_e;

endpackage

// File: rtl/ifu_inst_buf.sv
// Single-entry decode payload register {inst, PC, PC_S, fault} plus its valid bit.
// Load captures a new payload, clear drops only the valid bit, hold keeps everything.
module ifu_inst_buf
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_LEN = IFU_DATA_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  buf_op_e             i_op,
  input  logic [31:0]         i_inst,
  input  logic [DATA_LEN-1:0] i_pc,
  input  logic [DATA_LEN-1:0] i_pc_s,
  input  logic                i_fault,
  output logic                o_valid,
  output logic [31:0]         o_inst,
  output logic [DATA_LEN-1:0] o_pc,
  output logic [DATA_LEN-1:0] o_pc_s,
  output logic                o_fault
);

  logic                r_valid;
  logic [31:0]         r_inst;
  logic [DATA_LEN-1:0] r_pc;
  logic [DATA_LEN-1:0] r_pc_s;
  logic                r_fault;

  // NOTE: the payload is reset too, not just the valid bit, because decode must see
  // all-zero inst/PC/PC_S while the unit is held in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
      r_pc_s  <= '0;
      r_fault <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (i_op)
        BUF_LOAD: begin
          r_valid <= 1'b1;
          r_inst  <= i_inst;
          r_pc    <= i_pc;
          r_pc_s  <= i_pc_s;
          r_fault <= i_fault;
        end
        BUF_CLEAR: r_valid <= 1'b0;
        default:   r_valid <= r_valid;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_pc_s  = r_pc_s;
  assign o_fault = r_fault;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one fetch in flight and hands
// {inst, PC, PC_S, fault} to decode; redirects from execute override everything.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned          DATA_LEN = IFU_DATA_LEN,
  parameter logic [DATA_LEN-1:0]  RST_PC   = DATA_LEN'(IFU_RST_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_valid,
  input  logic [DATA_LEN-1:0] jump_addr,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                imem_rsp_err,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [DATA_LEN-1:0] PC,
  output logic [DATA_LEN-1:0] PC_S,
  output logic                inst_fault
);

  ifu_state_e          r_state;
  ifu_state_e          w_state_nxt;
  logic [DATA_LEN-1:0] r_pc;
  logic [DATA_LEN-1:0] w_pc_nxt;
  logic                r_drop;
  logic                w_drop_nxt;

  logic [DATA_LEN-1:0] w_pc_inc;
  logic                w_misaligned;
  logic                w_req_fire;
  buf_op_e             w_buf_op;
  logic [31:0]         w_buf_inst;
  logic                w_buf_fault;

  assign w_pc_inc     = r_pc + DATA_LEN'(4);
  assign w_misaligned = (r_pc[1:0] != 2'b00);

  // A misaligned PC never reaches memory; the fault is synthesised locally instead.
  assign imem_req_valid = !rst && (r_state == S_REQ) && !w_misaligned;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RST_PC;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_buf_op    = BUF_HOLD;
    w_buf_inst  = NOP_INST;
    w_buf_fault = 1'b0;

    case (r_state)
      S_REQ: begin
        if (jump_valid) begin
          // An accepted request to the old PC is still in flight; mark it stale.
          w_pc_nxt = jump_addr;
          if (w_req_fire) begin
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end else if (w_misaligned) begin
          w_buf_op    = BUF_LOAD;
          w_buf_fault = 1'b1;
          w_state_nxt = S_VALID;
        end else if (w_req_fire) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (jump_valid) begin
          w_pc_nxt = jump_addr;
          if (imem_rsp_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_buf_op    = BUF_LOAD;
            w_buf_inst  = imem_rsp_err ? NOP_INST : imem_rsp_data;
            w_buf_fault = imem_rsp_err;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_VALID;
          end
        end
      end

      S_VALID: begin
        if (jump_valid) begin
          w_pc_nxt    = jump_addr;
          w_buf_op    = BUF_CLEAR;
          w_state_nxt = S_REQ;
        end else if (inst_ready) begin
          w_buf_op    = BUF_CLEAR;
          w_state_nxt = S_REQ;
        end
      end

      default: w_state_nxt = S_REQ;
    endcase
  end

  // Buffer PC/PC_S come from pc_q before its increment, so they name the fetched word.
  ifu_inst_buf #(
    .DATA_LEN (DATA_LEN)
  ) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .i_op    (w_buf_op),
    .i_inst  (w_buf_inst),
    .i_pc    (r_pc),
    .i_pc_s  (w_pc_inc),
    .i_fault (w_buf_fault),
    .o_valid (inst_valid),
    .o_inst  (inst),
    .o_pc    (PC),
    .o_pc_s  (PC_S),
    .o_fault (inst_fault)
  );

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by a randomized run
// against an architectural next-PC model and a simple one-outstanding memory.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] PC;
  logic [31:0] PC_S;
  logic        inst_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifu #(
    .DATA_LEN (32),
    .RST_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_valid     (jump_valid),
    .jump_addr      (jump_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .PC             (PC),
    .PC_S           (PC_S),
    .inst_fault     (inst_fault)
  );

  // Responses are only legal while a request is in flight.
  bit outstanding;
  always @(posedge clk) begin
    if (rst) outstanding <= 1'b0;
    else begin
      if (imem_rsp_valid) outstanding <= 1'b0;
      if (imem_req_valid && imem_req_ready) outstanding <= 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!rst && imem_rsp_valid)
      assert (outstanding) else $error("protocol violation: response with no request in flight");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F17;
  endfunction

  function automatic logic err_at(input logic [31:0] a);
    return (a[5:2] == 4'hB);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jump_valid     = 1'b0;
    jump_addr      = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Accept the pending request, answer it one cycle later.
  task automatic fetch(input logic [31:0] data, input logic err);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if ({inst_valid, inst_fault} !== 2'b00) begin failures++; $display("FAIL reset_valid_fault: got %b want 00", {inst_valid, inst_fault}); end
    checks++; if ({inst, PC, PC_S} !== 96'h0) begin failures++; $display("FAIL reset_payload: got %h want 0", {inst, PC, PC_S}); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin failures++; $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RST_PC); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL first_wait: got req=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093) begin failures++; $display("FAIL first_inst: got v=%b i=%h want v=1 i=00100093", inst_valid, inst); end
    checks++; if (PC !== 32'h8000_0000 || PC_S !== 32'h8000_0004) begin failures++; $display("FAIL first_pc: got %h/%h want 80000000/80000004", PC, PC_S); end
    checks++; if (inst_fault !== 1'b0) begin failures++; $display("FAIL first_fault: got %b want 0", inst_fault); end
  endtask

  task automatic test_stall();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || PC !== 32'h8000_0000 || imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b i=%h pc=%h req=%b want 1 00100093 80000000 0", i, inst_valid, inst, PC, imem_req_valid);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stall_release_valid: got %b want 0", inst_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin failures++; $display("FAIL stall_next_req: got v=%b a=%h want 1 80000004", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_jump_wait();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    jump_valid = 1'b1;
    jump_addr  = 32'h8000_0100;
    tick();
    jump_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL jw_still_wait: got req=%b want 0", imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL jw_dropped: got iv=%b want 0", inst_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin failures++; $display("FAIL jw_target_req: got v=%b a=%h want 1 80000100", imem_req_valid, imem_req_addr); end
    fetch(32'h0020_0113, 1'b0);
    checks++; if (inst_valid !== 1'b1 || PC !== 32'h8000_0100 || inst !== 32'h0020_0113) begin failures++; $display("FAIL jw_target_inst: got v=%b pc=%h i=%h want 1 80000100 00200113", inst_valid, PC, inst); end
  endtask

  task automatic test_jump_handshake();
    do_reset();
    imem_req_ready = 1'b1;
    jump_valid     = 1'b1;
    jump_addr      = 32'h8000_0200;
    tick();
    imem_req_ready = 1'b0;
    jump_valid     = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL jh_wait: got req=%b want 0", imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin failures++; $display("FAIL jh_stale_dropped: got iv=%b req=%b a=%h want 0 1 80000200", inst_valid, imem_req_valid, imem_req_addr); end
    fetch(32'h0030_0193, 1'b0);
    checks++; if (inst_valid !== 1'b1 || PC !== 32'h8000_0200 || PC_S !== 32'h8000_0204 || inst !== 32'h0030_0193) begin failures++; $display("FAIL jh_target_inst: got v=%b pc=%h pcs=%h i=%h", inst_valid, PC, PC_S, inst); end
  endtask

  task automatic test_misaligned();
    do_reset();
    jump_valid = 1'b1;
    jump_addr  = 32'h8000_0102;
    tick();
    jump_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_no_req: got req=%b want 0", imem_req_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== NOP_INST) begin failures++; $display("FAIL mis_fault: got v=%b f=%b i=%h want 1 1 00000013", inst_valid, inst_fault, inst); end
    checks++; if (PC !== 32'h8000_0102 || PC_S !== 32'h8000_0106 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_pc: got %h/%h req=%b want 80000102/80000106 0", PC, PC_S, imem_req_valid); end
    jump_valid = 1'b1;
    jump_addr  = 32'h8000_0300;
    inst_ready = 1'b1;
    tick();
    jump_valid = 1'b0;
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin failures++; $display("FAIL mis_redirect: got iv=%b req=%b a=%h want 0 1 80000300", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_bus_error();
    fetch(32'h1234_5678, 1'b1);
    checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== NOP_INST) begin failures++; $display("FAIL berr_fault: got v=%b f=%b i=%h want 1 1 00000013", inst_valid, inst_fault, inst); end
    checks++; if (PC !== 32'h8000_0300 || PC_S !== 32'h8000_0304) begin failures++; $display("FAIL berr_pc: got %h/%h want 80000300/80000304", PC, PC_S); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0304) begin failures++; $display("FAIL berr_next_req: got v=%b a=%h want 1 80000304", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    fetch(32'h0040_0213, 1'b0);
    inst_ready = 1'b1;
    tick();
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if ({imem_req_valid, inst_valid, inst_fault} !== 3'b000) begin failures++; $display("FAIL rstw_flags: got %b want 000", {imem_req_valid, inst_valid, inst_fault}); end
    checks++; if ({inst, PC, PC_S} !== 96'h0) begin failures++; $display("FAIL rstw_payload: got %h want 0", {inst, PC, PC_S}); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin failures++; $display("FAIL rstw_restart: got v=%b a=%h want 1 %h", imem_req_valid, imem_req_addr, RST_PC); end
  endtask

  // exp_pc is the address of the next instruction decode should receive.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] maddr;
    logic [31:0] p_inst, p_pc, p_pcs;
    logic        p_fault;
    logic        exp_fault;
    logic [31:0] ja;
    bit          busy, hold_prev, jumped_valid;
    int          cnt, delivered, sel;
    do_reset();
    exp_pc = RST_PC; busy = 1'b0; cnt = 0; maddr = '0;
    hold_prev = 1'b0; jumped_valid = 1'b0; delivered = 0;
    p_inst = '0; p_pc = '0; p_pcs = '0; p_fault = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (imem_req_valid) begin
        checks++; if (imem_req_addr !== exp_pc) begin failures++; $display("FAIL rnd_req_addr@%0d: got %h want %h", cyc, imem_req_addr, exp_pc); end
        checks++; if (busy) begin failures++; $display("FAIL rnd_two_outstanding@%0d: got req while busy want none", cyc); end
      end
      if (inst_valid) begin
        exp_fault = (exp_pc[1:0] != 2'b00) || err_at(exp_pc);
        checks++; if (PC !== exp_pc || PC_S !== exp_pc + 32'd4) begin failures++; $display("FAIL rnd_pc@%0d: got %h/%h want %h/%h", cyc, PC, PC_S, exp_pc, exp_pc + 32'd4); end
        checks++; if (inst_fault !== exp_fault) begin failures++; $display("FAIL rnd_fault@%0d: got %b want %b", cyc, inst_fault, exp_fault); end
        checks++; if (inst !== (exp_fault ? NOP_INST : mem_word(exp_pc))) begin failures++; $display("FAIL rnd_inst@%0d: got %h want %h", cyc, inst, exp_fault ? NOP_INST : mem_word(exp_pc)); end
      end
      if (hold_prev) begin
        checks++;
        if (inst_valid !== 1'b1 || inst !== p_inst || PC !== p_pc || PC_S !== p_pcs || inst_fault !== p_fault) begin
          failures++; $display("FAIL rnd_hold@%0d: got v=%b i=%h pc=%h want 1 %h %h", cyc, inst_valid, inst, PC, p_inst, p_pc);
        end
      end
      if (jumped_valid) begin
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rnd_jump_flush@%0d: got iv=%b want 0", cyc, inst_valid); end
      end

      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'($urandom_range(0, 1));
      if (busy) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(maddr);
          imem_rsp_err   = err_at(maddr);
          busy = 1'b0;
        end else cnt--;
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      jump_valid     = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 7);
      ja  = $urandom;
      if (sel == 0) begin
        if (ja[1:0] == 2'b00) ja[0] = 1'b1;
      end else if (sel == 1) begin
        ja = 32'hFFFF_FFF8;
      end else begin
        ja = 32'h8000_0000 + 32'($urandom_range(0, 255) * 4);
      end
      jump_addr = ja;

      hold_prev    = inst_valid && !inst_ready && !jump_valid;
      jumped_valid = inst_valid && jump_valid;
      p_inst = inst; p_pc = PC; p_pcs = PC_S; p_fault = inst_fault;
      if (imem_req_valid && imem_req_ready) begin
        busy  = 1'b1;
        maddr = imem_req_addr;
        cnt   = $urandom_range(0, 3);
      end
      if (jump_valid) exp_pc = jump_addr;
      else if (inst_valid && inst_ready) begin
        delivered++;
        if (exp_pc[1:0] == 2'b00) exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    idle_inputs();
    checks++; if (delivered < 200) begin failures++; $display("FAIL rnd_progress: got %0d deliveries want >=200", delivered); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_stall();
    test_jump_wait();
    test_jump_handshake();
    test_misaligned();
    test_bus_error();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
